// File: rtl/basic_io_pkg.sv
// basic_io_pkg -- shared constants for the BASIC INPUT statement reader.
//   ASCII codes recognised by the parser, the reader state enum and the
//   default result width (matches the BASIC integer variable width).
package basic_io_pkg;
    localparam int DATA_W_DEF = 32;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] PLUS  = 8'h2B;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] NINE  = 8'h39;

    typedef enum logic [1:0] {IDLE, SIGN, DIGITS, FINISH} state_t;
endpackage

// File: rtl/basic_digit_decode.sv
// basic_digit_decode -- combinational classifier for one input byte.
//   in_data  : ASCII byte
//   is_digit : byte is '0'..'9'
//   is_term  : byte is CR or LF (line terminator)
//   digit    : numeric value of the byte when is_digit
module basic_digit_decode
    import basic_io_pkg::*;
(
    input  logic [7:0] in_data,
    output logic       is_digit,
    output logic       is_term,
    output logic [3:0] digit
);
    assign is_digit = (in_data >= ZERO) && (in_data <= NINE);
    assign is_term  = (in_data == CR) || (in_data == LF);
    // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
    assign digit    = in_data[3:0];
endmodule

// File: rtl/basic_input_reader.sv
// basic_input_reader -- parses one signed decimal integer from an ASCII
// byte stream for the BASIC INPUT statement.
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   start            : one-cycle pulse that begins a parse (IDLE only)
//   in_valid/in_data : byte stream; a byte moves on in_valid && in_ready
//   in_ready         : high while the reader is in SIGN or DIGITS
//   value            : parsed signed result, held until the next parse ends
//   done             : one-cycle pulse the cycle after the terminator
//   err              : qualifies done (malformed, empty or overflowed)
// Optional build macro BASIC_INPUT_ECHO_EN echoes accepted bytes and
// prints "?ERR" for a failed parse (simulation only).
module basic_input_reader
    import basic_io_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_DIGITS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] value,
    output logic              done,
    output logic              err
);
    localparam int AW = DATA_W + 4;
    localparam int CW = $clog2(MAX_DIGITS + 2);
    localparam logic [AW-1:0]     LIM_NEG = AW'(1) << (DATA_W - 1);
    localparam logic [AW-1:0]     LIM_POS = LIM_NEG - AW'(1);
    localparam logic [DATA_W-1:0] VMAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] VMIN    = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            r_state, w_next;
    logic [AW-1:0]     r_acc;
    logic              r_neg, r_bad, r_ovf;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_value;
    logic              r_err;

    logic          w_is_digit, w_is_term, w_accept;
    logic [3:0]    w_digit;
    logic [AW-1:0] w_acc_next, w_lim;
    logic [CW-1:0] w_cnt_inc;
    logic          w_num_ovf, w_cnt_ovf;
    logic [DATA_W-1:0] w_res;
    logic          w_res_err;

    basic_digit_decode u_dec (
        .in_data  (in_data),
        .is_digit (w_is_digit),
        .is_term  (w_is_term),
        .digit    (w_digit)
    );

    assign in_ready = (r_state == SIGN) || (r_state == DIGITS);
    assign w_accept = in_valid && in_ready;
    assign done     = (r_state == FINISH);
    assign value    = r_value;
    assign err      = r_err;

    // Once overflowed, acc is clamped to the limit so acc*10+9 always fits
    // in the extra four bits and further digits cannot wrap it.
    assign w_acc_next = r_acc * AW'(10) + AW'(w_digit);
    assign w_lim      = r_neg ? LIM_NEG : LIM_POS;
    assign w_num_ovf  = (w_acc_next > w_lim);
    // digit counter saturates one past the limit
    assign w_cnt_inc  = (r_cnt == CW'(MAX_DIGITS + 1)) ? r_cnt : r_cnt + CW'(1);
    assign w_cnt_ovf  = (w_cnt_inc > CW'(MAX_DIGITS));

    // Result is latched on the terminator edge so it is valid while done is high.
    assign w_res     = r_ovf ? (r_neg ? VMIN : VMAX)
                             : (r_neg ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0]);
    assign w_res_err = r_bad || r_ovf || (r_cnt == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (start) w_next = SIGN;
            SIGN:   if (w_accept) begin
                        if (w_is_term)
                            w_next = FINISH;
                        else if (w_is_digit || in_data == MINUS || in_data == PLUS)
                            w_next = DIGITS;
                    end
            DIGITS: if (w_accept && w_is_term) w_next = FINISH;
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_bad   <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_value <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_acc <= '0;
                r_neg <= 1'b0;
                r_bad <= 1'b0;
                r_ovf <= 1'b0;
                r_cnt <= '0;
            end
            if (w_accept) begin
                if (w_is_term) begin
                    r_value <= w_res;
                    r_err   <= w_res_err;
                end else if (w_is_digit) begin
                    r_cnt <= w_cnt_inc;
                    if (w_num_ovf) begin
                        r_acc <= w_lim;
                        r_ovf <= 1'b1;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                    if (w_cnt_ovf) r_ovf <= 1'b1;
                end else if (r_state == SIGN && in_data == MINUS) begin
                    r_neg <= 1'b1;
                end else if (!(r_state == SIGN && (in_data == PLUS || in_data == SPACE))) begin
                    // stray character: remembered, otherwise ignored
                    r_bad <= 1'b1;
                end
            end
        end
    end

`ifdef BASIC_INPUT_ECHO_EN
    always @(posedge clk) begin
        if (!reset && w_accept) $write("%c", in_data);
        if (!reset && r_state == FINISH && r_err) $display("?ERR");
    end
`endif
endmodule

// File: tb/tb_basic_input_reader.sv
module tb_basic_input_reader;
    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, done, err;
    logic [31:0] value;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    basic_input_reader #(.DATA_W(32), .MAX_DIGITS(10)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .value(value),
        .done(done), .err(err)
    );

    typedef struct packed {
        logic [127:0] s;
        logic         tog;
        logic [31:0]  val;
        logic         err;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // done must never stay high two cycles in a row
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            n_cmp++;
            if (prev_done) begin
                n_bad++;
                $display("FAIL done_twice: got 1 want 0");
            end
        end
        prev_done = done;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run(input string nm, input logic [127:0] s, input logic tog,
                       input logic [31:0] ev, input logic ee);
        int n;
        int early;
        n = 0;
        early = 0;
        for (int k = 15; k >= 0; k--)
            if (n == 0 && s[8*k +: 8] != 8'h00) n = k + 1;
        pulse_start();
        for (int i = n - 1; i >= 0; i--) begin
            if (tog) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_data  = 8'h33;   // a digit that must not be consumed
                    @(posedge clk); #1;
                    if (done) early++;
                end
            end
            in_valid = 1'b1;
            in_data  = s[8*i +: 8];
            @(posedge clk); #1;
            if (i > 0 && done) early++;
        end
        in_valid = 1'b0;
        check({nm, "_early"}, 32'(early), 32'd0);
        check({nm, "_done"}, {31'd0, done}, 32'd1);
        check({nm, "_value"}, value, ev);
        check({nm, "_err"}, {31'd0, err}, {31'd0, ee});
        @(posedge clk); #1;
        check({nm, "_done_off"}, {31'd0, done}, 32'd0);
    endtask

    vec_t vt[13];

    initial begin
        int dc;
        vt[0]  = '{128'("  -123\n"),      1'b0, -123,         1'b0};
        vt[1]  = '{128'("2147483648\n"),  1'b0, 2147483647,   1'b1};
        vt[2]  = '{128'("-2147483648\n"), 1'b0, 32'h80000000, 1'b0};
        vt[3]  = '{128'("\n"),            1'b0, 0,            1'b1};
        vt[4]  = '{128'("-\n"),           1'b0, 0,            1'b1};
        vt[5]  = '{128'("12a3\n"),        1'b0, 123,          1'b1};
        vt[6]  = '{128'("12a3\n"),        1'b1, 123,          1'b1};
        vt[7]  = '{128'("+42\r"),         1'b0, 42,           1'b0};
        vt[8]  = '{128'("2147483647\n"),  1'b0, 2147483647,   1'b0};
        vt[9]  = '{128'("-2147483649\n"), 1'b0, 32'h80000000, 1'b1};
        vt[10] = '{128'("x5\n"),          1'b0, 5,            1'b1};
        vt[11] = '{128'("0\n"),           1'b1, 0,            1'b0};
        vt[12] = '{128'(" -98765\r"),     1'b1, -98765,       1'b0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_done",  {31'd0, done},     32'd0);
        check("rst_value", value,             32'd0);
        check("rst_err",   {31'd0, err},      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        for (int i = 0; i < 13; i++)
            run($sformatf("v%0d", i), vt[i].s, vt[i].tog, vt[i].val, vt[i].err);

        // reset in the middle of a parse: no done, outputs cleared
        pulse_start();
        put("4");
        put("5");
        dc = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ready", {31'd0, in_ready}, 32'd0);
        check("abort_value", value, 32'd0);
        check("abort_err",   {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_nodone", 32'(done_cnt - dc), 32'd0);
        run("after_abort", 128'("7\n"), 1'b0, 7, 1'b0);

        // start while in DIGITS is ignored
        pulse_start();
        put("1");
        put("2");
        start = 1'b1; in_valid = 1'b1; in_data = "3";
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        check("dig_start_ready", {31'd0, in_ready}, 32'd1);
        put(8'h0A);
        check("dig_start_done",  {31'd0, done}, 32'd1);
        check("dig_start_value", value, 32'd123);
        check("dig_start_err",   {31'd0, err}, 32'd0);

        // start during done is ignored; start the cycle after is accepted
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("done_start_idle", {31'd0, in_ready}, 32'd0);
        pulse_start();
        check("b2b_ready", {31'd0, in_ready}, 32'd1);
        put("8");
        put(8'h0A);
        check("b2b_done",  {31'd0, done}, 32'd1);
        check("b2b_value", value, 32'd8);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_ignored", {31'd0, in_ready}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_next_ready", {31'd0, in_ready}, 32'd1);
        put("6");
        put(8'h0D);
        check("b2b2_value", value, 32'd6);
        check("b2b2_err", {31'd0, err}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/basic_input_reader.md
BASIC_INPUT_READER -- requirements
Module: basic_input_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of the signed result, matching the BASIC integer variables.
REQ-002 SHALL have parameter MAX_DIGITS, default 10, the maximum magnitude digits accepted before overflow.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse from the INPUT statement's control bit.
REQ-006 SHALL have port in_valid  input  1  an input byte is present.
REQ-007 SHALL have port in_data  input  8  ASCII byte.
REQ-008 SHALL have port in_ready  output  1  the reader accepts a byte this cycle.
REQ-009 SHALL have port value  output  DATA_W  the parsed signed integer, held between operations.
REQ-010 SHALL have port done  output  1  one-cycle pulse that passes control to the next statement.
REQ-011 SHALL have port err  output  1  qualifies done; the parse was malformed or overflowed.

Function
REQ-012 SHALL implement the states IDLE, SIGN, DIGITS and FINISH.
REQ-013 SHALL accept a byte only on in_valid && in_ready, and in_ready SHALL be 1 only in SIGN and DIGITS.
REQ-014 SHALL move IDLE->SIGN on the cycle after start==1, and SHALL ignore start in any other state.
REQ-015 In SIGN, SHALL skip a space (0x20), set neg and go to DIGITS on '-' (0x2D), go to DIGITS on '+' (0x2B), and go to DIGITS on a digit '0'-'9' after accumulating it.
REQ-016 In SIGN, on CR (0x0D) or LF (0x0A), SHALL go to FINISH with err=1 and value=0; on any other byte, SHALL set a sticky bad flag and stay in SIGN.
REQ-017 In DIGITS, on a digit, SHALL set acc = acc*10 + digit, computed in DATA_W+4 bits, and increment the digit count.
REQ-018 In DIGITS, on any other non-terminator byte, SHALL set the sticky bad flag and ignore the byte.
REQ-019 In DIGITS, on CR or LF, SHALL go to FINISH.
REQ-020 SHALL treat zero digits at the terminator as err=1 with value=0; a sign alone counts as zero digits.
REQ-021 SHALL set a sticky ovf flag on overflow, defined as magnitude > 2^(DATA_W-1)-1 when positive, magnitude > 2^(DATA_W-1) when negative, or digit count > MAX_DIGITS.
REQ-022 On overflow, SHALL saturate value to +max or -min respectively and keep consuming until the terminator.
REQ-023 In FINISH, for exactly one cycle, SHALL assert done=1, register value = neg ? -acc : acc, set err = bad|ovf|empty, then return to IDLE.
REQ-024 Latency SHALL be: done is high on the cycle after the terminator byte is accepted.
REQ-025 SHALL hold value and err until the next FINISH, and done SHALL never be high for two consecutive cycles.
REQ-026 A start pulse in the same cycle as done SHALL be ignored.
REQ-027 Back-to-back operations SHALL be accepted starting from the cycle after done.

Reset
REQ-028 When reset==1, the block SHALL go to IDLE and set in_ready=0, done=0, err=0, value=0, acc=0, neg=0, bad=0, ovf=0 and digit count=0.
REQ-029 Reset SHALL take priority over start and over byte acceptance, including reset in the middle of a parse.
REQ-030 A parse aborted by reset SHALL produce no done pulse.

Configuration
REQ-031 With macro BASIC_INPUT_ECHO_EN defined, every accepted byte SHALL be echoed with $write("%c") on the cycle it is accepted, and FINISH SHALL additionally $display("?ERR") when err=1.
REQ-032 Without BASIC_INPUT_ECHO_EN, no system tasks SHALL be compiled, and port-level behaviour SHALL be identical.

Structure
REQ-033 Package basic_io_pkg SHALL hold the ASCII constants (SPACE, PLUS, MINUS, CR, LF, ZERO, NINE), the state enum typedef and the DATA_W default.
REQ-034 Sub-module basic_digit_decode SHALL be purely combinational: in_data in; is_digit, is_term and digit[3:0] out. It is the only sub-module.

Verification
REQ-035 The bench SHALL cover: start, bytes "  -123\n" -> done one cycle after LF accepted, value=-123, err=0.
REQ-036 The bench SHALL cover: start, bytes "2147483648\n" -> value=2147483647, err=1; the same with a leading '-' -> value=-2147483648, err=0.
REQ-037 The bench SHALL cover: start, bytes "\n" and separately "-\n" -> value=0, err=1.
REQ-038 The bench SHALL cover: start, bytes "12a3\n" -> value=123, err=1; also in_valid toggled randomly during the parse -> same result, with no byte lost or duplicated.
REQ-039 The bench SHALL cover: start, bytes "45", then reset=1 for one cycle -> no done pulse, value=0; then start, bytes "7\n" -> value=7.
REQ-040 The bench SHALL cover: a start pulse while in DIGITS -> ignored, in_ready unchanged, and the result is that of the original parse.
